// File: rtl/cv32e40s_mpu_req_arbiter.sv
// Two-requester arbiter in front of the MPU core-side transaction port.
// Round-robin with split-transaction lock, OBI grant hold and in-order response routing.
module cv32e40s_mpu_req_arbiter #(
    parameter int REQ_W   = 72,
    parameter int RESP_W  = 36,
    parameter int MAX_OUT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m0_req_valid,
    input  logic                         m0_req_lock,
    input  logic [REQ_W-1:0]             m0_req,
    output logic                         m0_req_ready,
    output logic                         m0_resp_valid,
    input  logic                         m1_req_valid,
    input  logic                         m1_req_lock,
    input  logic [REQ_W-1:0]             m1_req,
    output logic                         m1_req_ready,
    output logic                         m1_resp_valid,
    output logic                         mpu_trans_valid,
    input  logic                         mpu_trans_ready,
    output logic [REQ_W-1:0]             mpu_trans,
    input  logic                         mpu_resp_valid,
    input  logic [RESP_W-1:0]            mpu_resp,
    output logic [RESP_W-1:0]            resp,
    output logic [$clog2(MAX_OUT):0]     outstanding_o,
    output logic                         unexpected_resp_o
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);

    logic             r_prio;
    logic             r_lock;
    logic             r_lock_owner;
    logic             r_hold;
    logic             r_hold_id;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_unexp;
    logic             r_fifo [MAX_OUT];

    logic w_grant;
    logic w_gvalid;
    logic w_glock;
    logic w_full;
    logic w_hs;
    logic w_pop;
    logic w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: w_grant gets a default before the priority chain so no latch is inferred.
    always_comb begin
        w_grant = 1'b0;
        if (r_hold)
            w_grant = r_hold_id;
        else if (r_lock)
            w_grant = r_lock_owner;
        else if (m0_req_valid && m1_req_valid)
            w_grant = r_prio;
        else
            w_grant = m1_req_valid;
    end

    assign w_gvalid = w_grant ? m1_req_valid : m0_req_valid;
    assign w_glock  = w_grant ? m1_req_lock  : m0_req_lock;
    assign w_full   = (r_cnt == CNT_FULL);

    // No bypass: a pop in the same cycle never frees a slot for a push while full.
    assign mpu_trans_valid = w_gvalid && !w_full && !rst;
    assign mpu_trans       = w_grant ? m1_req : m0_req;
    assign w_hs            = mpu_trans_valid && mpu_trans_ready;
    assign m0_req_ready    = w_hs && !w_grant;
    assign m1_req_ready    = w_hs &&  w_grant;

    assign w_pop             = mpu_resp_valid && (r_cnt != '0) && !rst;
    assign w_head            = r_fifo[r_rd_ptr];
    assign m0_resp_valid     = w_pop && !w_head;
    assign m1_resp_valid     = w_pop &&  w_head;
    assign resp              = mpu_resp;
    assign outstanding_o     = r_cnt;
    assign unexpected_resp_o = r_unexp;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio       <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_owner <= 1'b0;
            r_hold       <= 1'b0;
            r_hold_id    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_unexp      <= 1'b0;
        end else begin
            r_unexp <= mpu_resp_valid && (r_cnt == '0);

            if (w_hs) begin
                r_hold       <= 1'b0;
                r_lock       <= w_glock;
                r_lock_owner <= w_grant;
                if (!w_glock)
                    r_prio <= !w_grant;
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end else if (mpu_trans_valid) begin
                r_hold    <= 1'b1;
                r_hold_id <= w_grant;
            end

            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);

            r_cnt <= r_cnt + CNT_W'(w_hs) - CNT_W'(w_pop);
        end
    end

    // NOTE: ID storage is not reset; entries are only read while r_cnt says they are valid.
    always_ff @(posedge clk) begin
        if (w_hs)
            r_fifo[r_wr_ptr] <= w_grant;
    end

endmodule

// File: tb/tb_cv32e40s_mpu_req_arbiter.sv
// Scoreboard bench for cv32e40s_mpu_req_arbiter: expected owner IDs are queued at issue
// and matched against the routed response valids.
module tb_cv32e40s_mpu_req_arbiter;

    localparam int REQ_W   = 72;
    localparam int RESP_W  = 36;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = $clog2(MAX_OUT) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req_valid, m0_req_lock, m0_req_ready, m0_resp_valid;
    logic              m1_req_valid, m1_req_lock, m1_req_ready, m1_resp_valid;
    logic [REQ_W-1:0]  m0_req, m1_req, mpu_trans;
    logic              mpu_trans_valid, mpu_trans_ready, mpu_resp_valid;
    logic [RESP_W-1:0] mpu_resp, resp;
    logic [CNT_W-1:0]  outstanding_o;
    logic              unexpected_resp_o;

    cv32e40s_mpu_req_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .MAX_OUT(MAX_OUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .m0_req_valid      (m0_req_valid),
        .m0_req_lock       (m0_req_lock),
        .m0_req            (m0_req),
        .m0_req_ready      (m0_req_ready),
        .m0_resp_valid     (m0_resp_valid),
        .m1_req_valid      (m1_req_valid),
        .m1_req_lock       (m1_req_lock),
        .m1_req            (m1_req),
        .m1_req_ready      (m1_req_ready),
        .m1_resp_valid     (m1_resp_valid),
        .mpu_trans_valid   (mpu_trans_valid),
        .mpu_trans_ready   (mpu_trans_ready),
        .mpu_trans         (mpu_trans),
        .mpu_resp_valid    (mpu_resp_valid),
        .mpu_resp          (mpu_resp),
        .resp              (resp),
        .outstanding_o     (outstanding_o),
        .unexpected_resp_o (unexpected_resp_o)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_err = 0;
    bit               sb_q[$];
    bit               exp_unexp;
    logic [REQ_W-1:0] m0_pay, m1_pay;

    task automatic check(input string tag, input logic [REQ_W-1:0] obs, input logic [REQ_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] rand_pay();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    // rv: 0 = no response, 1 = respond if anything is outstanding, 2 = respond unconditionally
    task automatic cyc(input string tag, input bit v0, input bit l0, input bit v1, input bit l1,
                       input bit rdy, input int rv, input bit exp_tv, input bit exp_g);
        bit                was_empty;
        bit                hs;
        bit                id;
        logic [RESP_W-1:0] rdata;
        m0_req_valid    = v0;
        m0_req_lock     = l0;
        m1_req_valid    = v1;
        m1_req_lock     = l1;
        m0_req          = m0_pay;
        m1_req          = m1_pay;
        mpu_trans_ready = rdy;
        mpu_resp_valid  = (rv == 2) || (rv == 1 && sb_q.size() > 0);
        rdata           = RESP_W'({$urandom, $urandom});
        mpu_resp        = rdata;
        @(negedge clk);
        was_empty = (sb_q.size() == 0);
        hs        = exp_tv && rdy;
        check({tag, ":outstanding"}, REQ_W'(outstanding_o), REQ_W'(sb_q.size()));
        check({tag, ":unexpected"}, REQ_W'(unexpected_resp_o), REQ_W'(exp_unexp));
        check({tag, ":trans_valid"}, REQ_W'(mpu_trans_valid), REQ_W'(exp_tv));
        check({tag, ":m0_ready"}, REQ_W'(m0_req_ready), REQ_W'(hs && !exp_g));
        check({tag, ":m1_ready"}, REQ_W'(m1_req_ready), REQ_W'(hs && exp_g));
        if (exp_tv)
            check({tag, ":payload"}, mpu_trans, exp_g ? m1_pay : m0_pay);
        if (mpu_resp_valid && !was_empty) begin
            id = sb_q.pop_front();
            check({tag, ":m0_resp"}, REQ_W'(m0_resp_valid), REQ_W'(!id));
            check({tag, ":m1_resp"}, REQ_W'(m1_resp_valid), REQ_W'(id));
            check({tag, ":resp"}, REQ_W'(resp), REQ_W'(rdata));
        end else begin
            check({tag, ":m0_resp_idle"}, REQ_W'(m0_resp_valid), '0);
            check({tag, ":m1_resp_idle"}, REQ_W'(m1_resp_valid), '0);
        end
        exp_unexp = mpu_resp_valid && was_empty;
        if (hs)
            sb_q.push_back(exp_g);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_phase(input string tag);
        rst            = 1'b1;
        m0_req_valid   = 1'b1;
        m1_req_valid   = 1'b1;
        mpu_resp_valid = 1'b1;
        @(negedge clk);
        check({tag, ":outstanding"}, REQ_W'(outstanding_o), '0);
        check({tag, ":trans_valid"}, REQ_W'(mpu_trans_valid), '0);
        check({tag, ":m0_ready"}, REQ_W'(m0_req_ready), '0);
        check({tag, ":m1_ready"}, REQ_W'(m1_req_ready), '0);
        check({tag, ":m0_resp"}, REQ_W'(m0_resp_valid), '0);
        check({tag, ":m1_resp"}, REQ_W'(m1_resp_valid), '0);
        check({tag, ":unexpected"}, REQ_W'(unexpected_resp_o), '0);
        sb_q.delete();
        exp_unexp = 1'b0;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        m0_req_valid   = 1'b0;
        m1_req_valid   = 1'b0;
        mpu_resp_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        m0_req_valid    = 1'b0;
        m0_req_lock     = 1'b0;
        m1_req_valid    = 1'b0;
        m1_req_lock     = 1'b0;
        m0_pay          = rand_pay();
        m1_pay          = rand_pay();
        m0_req          = m0_pay;
        m1_req          = m1_pay;
        mpu_trans_ready = 1'b0;
        mpu_resp_valid  = 1'b0;
        mpu_resp        = '0;
        exp_unexp       = 1'b0;
        #1;
        reset_phase("rst_init");

        // Round-robin alternation, one response per cycle
        for (int i = 0; i < 4; i++) begin
            m0_pay = rand_pay();
            m1_pay = rand_pay();
            cyc($sformatf("alt%0d", i), 1, 0, 1, 0, 1, (i == 0) ? 0 : 1, 1, i[0]);
        end
        cyc("alt_drain", 0, 0, 0, 0, 1, 1, 0, 0);

        // Lock held through an idle owner starves m1
        m0_pay = rand_pay();
        cyc("lk_set", 1, 1, 1, 0, 1, 1, 1, 0);
        cyc("lk_idle0", 0, 0, 1, 0, 1, 1, 0, 0);
        cyc("lk_idle1", 0, 0, 1, 0, 1, 1, 0, 0);
        m0_pay = rand_pay();
        cyc("lk_rel", 1, 0, 1, 0, 1, 1, 1, 0);
        m1_pay = rand_pay();
        cyc("lk_next", 1, 0, 1, 0, 1, 1, 1, 1);

        // Grant held on m1 while ready is low, even though prio favours m0
        m1_pay = rand_pay();
        cyc("hold0", 0, 0, 1, 0, 0, 1, 1, 1);
        m0_pay = rand_pay();
        cyc("hold1", 1, 0, 1, 0, 0, 1, 1, 1);
        m0_pay = rand_pay();
        cyc("hold2", 1, 0, 1, 0, 0, 1, 1, 1);
        cyc("hold_acc", 1, 0, 1, 0, 1, 1, 1, 1);
        cyc("hold_m0", 1, 0, 0, 0, 1, 1, 1, 0);
        cyc("f_drain", 0, 0, 0, 0, 1, 1, 0, 0);

        // Outstanding limit, no bypass on pop
        m0_pay = rand_pay();
        m1_pay = rand_pay();
        cyc("f0", 1, 0, 1, 0, 1, 0, 1, 1);
        cyc("f1", 1, 0, 1, 0, 1, 0, 1, 0);
        cyc("f_full", 1, 0, 1, 0, 1, 0, 0, 0);
        cyc("f_pop", 1, 0, 1, 0, 1, 1, 0, 0);
        cyc("f_issue", 1, 0, 1, 0, 1, 0, 1, 1);
        cyc("f_d0", 0, 0, 0, 0, 1, 1, 0, 0);
        cyc("f_d1", 0, 0, 0, 0, 1, 1, 0, 0);

        // Response with nothing outstanding
        cyc("unx", 0, 0, 0, 0, 1, 2, 0, 0);
        cyc("unx_pulse", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("unx_done", 0, 0, 0, 0, 1, 0, 0, 0);

        // Reset with full FIFO and lock active
        m0_pay = rand_pay();
        cyc("rl0", 1, 1, 1, 0, 1, 0, 1, 0);
        cyc("rl1", 1, 1, 1, 0, 1, 0, 1, 0);
        m0_req_lock = 1'b1;
        reset_phase("rst_mid");
        cyc("post_unx", 0, 0, 0, 0, 1, 2, 0, 0);
        m1_pay = rand_pay();
        cyc("post_m1", 0, 0, 1, 0, 1, 0, 1, 1);
        cyc("post_drain", 0, 0, 0, 0, 1, 1, 0, 0);
        cyc("post_idle", 0, 0, 0, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40s_mpu_req_arbiter.md
Name: cv32e40s_mpu_req_arbiter

Overview:
- Shares one MPU core-side transaction port between two requesters. Requester 0 is the LSU; requester 1 is a secondary master, for example a push/pop sequencer.
- Arbitration is round-robin, with lock support for split (misaligned) transactions and an OBI-stable grant hold.
- Responses come back in order. An in-order ID FIFO routes each MPU response, including MPU error completions, to the requester that issued it.
- The block sits between the requesters and the MPU core interface.

Parameters:
- REQ_W, 72, width of the packed request payload (addr, we, be, wdata, prot, dbg) forwarded unchanged.
- RESP_W, 36, width of the packed response payload (bus_resp plus mpu_status) forwarded unchanged.
- MAX_OUT, 2, maximum outstanding accepted transactions. Power of two, at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m0_req_valid  in  1  requester 0 request valid
- m0_req_lock  in  1  requester 0 requests that the grant be held after this transfer
- m0_req  in  REQ_W  requester 0 payload
- m0_req_ready  out  1  requester 0 transfer accepted
- m0_resp_valid  out  1  response for requester 0
- m1_req_valid, m1_req_lock, m1_req, m1_req_ready, m1_resp_valid  (as for requester 0)
- mpu_trans_valid  out  1  request to the MPU
- mpu_trans_ready  in  1  MPU accepts the request
- mpu_trans  out  REQ_W  muxed payload
- mpu_resp_valid  in  1  MPU response valid (bus response or MPU error completion)
- mpu_resp  in  RESP_W  response payload
- resp  out  RESP_W  mpu_resp broadcast to both requesters; qualified by mX_resp_valid
- outstanding_o  out  $clog2(MAX_OUT)+1  current outstanding count
- unexpected_resp_o  out  1  one-cycle pulse on a response received with no transaction outstanding

Behaviour:
- Registered state and reset values (rst=1, async):
  - prio_q = 0 (requester 0 preferred)
  - lock_q = 0, lock_owner_q = 0
  - hold_q = 0, hold_id_q = 0
  - FIFO wr_ptr = rd_ptr = 0, cnt = 0
  - unexpected_resp_o = 0
- Outputs are combinational from state and inputs. During reset all valid/ready outputs are 0, because the requester valids are ignored while rst=1.
- Grant selection, in priority order:
  - hold_q=1: grant hold_id_q.
  - else lock_q=1: grant lock_owner_q only; the other requester waits.
  - else both valid: grant prio_q.
  - else grant whichever requester is valid.
- full = (cnt == MAX_OUT).
- mpu_trans_valid = granted requester's valid && !full && !rst.
- mpu_trans = payload of the granted requester.
- mX_req_ready = (grant==X) && mpu_trans_valid && mpu_trans_ready.
- There is no full-bypass: a same-cycle pop never allows a push while full.
- Handshake = mpu_trans_valid && mpu_trans_ready. On a handshake by requester g:
  - push g into the FIFO;
  - set lock_q to mg_req_lock and lock_owner_q to g;
  - if mg_req_lock=0, set prio_q to !g.
- Stability:
  - If mpu_trans_valid=1 and mpu_trans_ready=0, set hold_q=1 and hold_id_q=grant.
  - Clear hold_q on the handshake.
  - The grant never changes while a request is pending.
- Response routing:
  - When mpu_resp_valid=1 and cnt>0: pop the FIFO head h, assert mh_resp_valid=1 in the same cycle (0-cycle latency), forward resp=mpu_resp.
  - Requesters must always accept responses; there is no response backpressure.
- Unexpected response: mpu_resp_valid with cnt==0 sets unexpected_resp_o=1 for the next cycle only. The response is dropped; state is unchanged.
- Simultaneous push and pop: both pointers advance, cnt is unchanged. This is legal at cnt==MAX_OUT only for the pop; no push occurs when full.
- Pointers wrap modulo MAX_OUT. cnt ranges 0..MAX_OUT.
- A lock with the requester going idle stays locked (the other requester starves) until the owner completes a transfer with lock=0.
- Reset asserted mid-transfer clears all state. Responses arriving after reset are reported as unexpected.

Test Plan:
- Both requesters valid continuously, ready=1, MAX_OUT=2, responses 1 cycle after each grant -> grants alternate 0,1,0,1; each mX_resp_valid matches its own issue order.
- m0 transfer with lock=1 followed by a lock=0 transfer while m1 is valid throughout -> two consecutive m0 grants, then m1; prio_q becomes 1 after the second.
- m1 valid, ready held 0 for 3 cycles while m0 asserts valid in cycle 2 -> mpu_trans stays on m1 with its payload stable until accepted; m0 is granted next.
- Issue 2 transfers with no response -> outstanding_o=2, mpu_trans_valid=0 despite a valid request; a response pops, outstanding_o=1, and the next cycle issues.
- Response at cnt=2 in the same cycle as a new request -> the pop completes and the request is blocked that cycle. Response with cnt=0 -> unexpected_resp_o pulses 1 cycle, no mX_resp_valid.
- Assert rst with cnt=2 and lock_q=1 -> outstanding_o=0, all readys 0 during reset; after release, m1 is grantable immediately.
